uart_tx_ctrl: RTL and testbench

UART transmit controller that serialises one byte per request onto the TX pin. Frame format is 8N1, with an optional even-parity bit. The block contains its own bit-period counter, so no external baud tick is needed. It is the transmit-side counterpart of the UART receive controller and drives host-bound result bytes out of the FPGA.

---
 rtl/uart_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8N1 framing with optional even parity and an internal bit-period counter.
// The line, busy and done outputs are registered and change together with the state on each edge.
module uart_tx_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_en_sig,
  input  logic [7:0] tx_data,
  output logic       tx_busy_sig,
  output logic       tx_done_sig,
  output logic       tx_pin_out
);

  localparam int unsigned BPS_CNT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    DATA0  = 4'd2,
    DATA1  = 4'd3,
    DATA2  = 4'd4,
    DATA3  = 4'd5,
    DATA4  = 4'd6,
    DATA5  = 4'd7,
    DATA6  = 4'd8,
    DATA7  = 4'd9,
    PARITY = 4'd10,
    STOP   = 4'd11,
    BFREE  = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             pin_q, pin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    shift_d = shift_q;
    par_d   = par_q;
    pin_d   = pin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pin_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_en_sig) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = ^tx_data;
          pin_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      // START and DATA0..6 share one path: the next state is the next encoding,
      // and the shift register presents the next data bit at its LSB.
      START, DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6: begin
        if (bit_end) begin
          state_d = state_e'(state_q + 4'd1);
          pin_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA7: begin
        if (bit_end) begin
          if (PARITY_EN != 0) begin
            state_d = PARITY;
            pin_d   = par_q;
          end else begin
            state_d = STOP;
            pin_d   = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          pin_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = BFREE;
          done_d  = 1'b1;
        end
      end
      BFREE: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pin_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_pin_out  = pin_q;
  assign tx_busy_sig = busy_q;
  assign tx_done_sig = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance without parity and one with, sharing stimulus.
module tb_uart_tx_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy [2];
  logic       done [2];
  logic       pin  [2];

  int compared   = 0;
  int mismatched = 0;

  logic log_pin  [2][0:259];
  logic log_busy [2][0:259];
  logic log_done [2][0:259];

  typedef struct {
    logic [7:0]  data;
    logic [10:0] exp0;
    logic [10:0] exp1;
  } vec_t;
  vec_t vecs [7];

  always #5 clock = ~clock;

  uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0)) u_p0 (
    .clock(clock), .reset(reset), .tx_en_sig(tx_en), .tx_data(tx_data),
    .tx_busy_sig(busy[0]), .tx_done_sig(done[0]), .tx_pin_out(pin[0])
  );

  uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1)) u_p1 (
    .clock(clock), .reset(reset), .tx_en_sig(tx_en), .tx_data(tx_data),
    .tx_busy_sig(busy[1]), .tx_done_sig(done[1]), .tx_pin_out(pin[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Index k of the logs is the sample taken after the k-th edge following the accept edge (k=0).
  // mode 0: single pulse; mode 1: tx_en held through a second accept; mode 2: pulses while busy.
  task automatic capture(input int mode, input logic [7:0] b, input int unsigned len);
    @(negedge clock);
    tx_en   = 1'b1;
    tx_data = b;
    for (int unsigned k = 0; k < len; k++) begin
      @(negedge clock);
      for (int unsigned d = 0; d < 2; d++) begin
        log_pin[d][k]  = pin[d];
        log_busy[d][k] = busy[d];
        log_done[d][k] = done[d];
      end
      case (mode)
        0: if (k == 0) begin tx_en = 1'b0; tx_data = ~b; end
        1: begin
          if (k == 0) tx_data = 8'hFF;
          if (k == 102) tx_en = 1'b0;
        end
        default: begin
          if (k == 0 || k == 5 || k == 50) tx_en = 1'b0;
          if (k == 4 || k == 49) begin tx_en = 1'b1; tx_data = 8'hFF; end
        end
      endcase
    end
    tx_en = 1'b0;
  endtask

  task automatic check_frame(input int unsigned d, input logic [10:0] frame,
                             input int unsigned base, input string tag);
    int unsigned nb  = 10 + d;
    int unsigned fin = base + nb * 10;
    logic [9:0]  act;
    logic [31:0] dn = 0;
    logic [31:0] bz = 0;
    for (int unsigned i = 0; i < nb; i++) begin
      for (int unsigned c = 0; c < 10; c++) act[c] = log_pin[d][base + 10 * i + c];
      chk($sformatf("%s_p%0d_bit%0d", tag, d, i), 32'(act), 32'({10{frame[i]}}));
    end
    for (int unsigned k = base; k <= fin + 1; k++) begin
      dn = dn + 32'(log_done[d][k]);
      bz = bz + 32'(log_busy[d][k]);
    end
    chk($sformatf("%s_p%0d_done_at_end", tag, d), 32'(log_done[d][fin]), 32'd1);
    chk($sformatf("%s_p%0d_done_count", tag, d), dn, 32'd1);
    chk($sformatf("%s_p%0d_busy_cycles", tag, d), bz, 32'(nb * 10 + 1));
    chk($sformatf("%s_p%0d_busy_fall", tag, d), 32'(log_busy[d][fin + 1]), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((busy[0] || busy[1]) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle_wait"}, 32'(busy[0] | busy[1]), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 11'h34A, 11'h54A};
    vecs[1] = '{8'h07, 11'h20E, 11'h60E};
    vecs[2] = '{8'h03, 11'h206, 11'h406};
    vecs[3] = '{8'h00, 11'h200, 11'h400};
    vecs[4] = '{8'hFF, 11'h3FE, 11'h5FE};
    vecs[5] = '{8'h01, 11'h202, 11'h602};
    vecs[6] = '{8'h80, 11'h300, 11'h700};

    reset = 1'b1;
    tx_en = 1'b1;
    repeat (3) begin
      @(negedge clock);
      for (int unsigned d = 0; d < 2; d++) begin
        chk($sformatf("rst_pin_p%0d", d), 32'(pin[d]), 32'd1);
        chk($sformatf("rst_busy_p%0d", d), 32'(busy[d]), 32'd0);
        chk($sformatf("rst_done_p%0d", d), 32'(done[d]), 32'd0);
      end
    end
    reset = 1'b0;
    tx_en = 1'b0;
    repeat (5) begin
      @(negedge clock);
      for (int unsigned d = 0; d < 2; d++) begin
        chk($sformatf("idle_pin_p%0d", d), 32'(pin[d]), 32'd1);
        chk($sformatf("idle_busy_p%0d", d), 32'(busy[d]), 32'd0);
      end
    end

    for (int unsigned v = 0; v < 7; v++) begin
      capture(0, vecs[v].data, 113);
      check_frame(0, vecs[v].exp0, 0, $sformatf("vec%0d", v));
      check_frame(1, vecs[v].exp1, 0, $sformatf("vec%0d", v));
      wait_idle($sformatf("vec%0d", v));
    end

    capture(2, 8'h55, 113);
    check_frame(0, 11'h2AA, 0, "busyreq");
    check_frame(1, 11'h4AA, 0, "busyreq");
    wait_idle("busyreq");

    capture(1, 8'h00, 204);
    check_frame(0, 11'h200, 0, "b2b_first");
    check_frame(0, 11'h3FE, 102, "b2b_second");
    chk("b2b_gap_bfree", 32'(log_pin[0][100]), 32'd1);
    chk("b2b_gap_idle", 32'(log_pin[0][101]), 32'd1);
    chk("b2b_start", 32'(log_pin[0][102]), 32'd0);
    check_frame(1, 11'h400, 0, "b2b_first");
    wait_idle("b2b");

    // Abort during DATA3 (samples 40..49 after accept).
    @(negedge clock);
    tx_en   = 1'b1;
    tx_data = 8'h00;
    for (int unsigned k = 0; k < 45; k++) begin
      @(negedge clock);
      if (k == 0) tx_en = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int unsigned d = 0; d < 2; d++) begin
      chk($sformatf("abort_pin_p%0d", d), 32'(pin[d]), 32'd1);
      chk($sformatf("abort_busy_p%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("abort_done_p%0d", d), 32'(done[d]), 32'd0);
    end
    begin
      logic [31:0] dn = 0;
      logic [31:0] lo = 0;
      repeat (150) begin
        @(negedge clock);
        dn = dn + 32'(done[0]) + 32'(done[1]);
        lo = lo + 32'(!pin[0]) + 32'(!pin[1]) + 32'(busy[0]) + 32'(busy[1]);
      end
      chk("abort_no_done", dn, 32'd0);
      chk("abort_line_idle", lo, 32'd0);
    end
    capture(0, 8'hA5, 113);
    check_frame(0, 11'h34A, 0, "post_abort");
    check_frame(1, 11'h54A, 0, "post_abort");
    wait_idle("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
